if_recurrent_core: RTL and testbench

Successor to the single recurrent IF layer. One recurrent integrate-and-fire layer with a built-in time-step sequencer: a start/busy/done handshake runs NUM_STEPS integration steps per sample. The layer adds configurable leak, per-neuron saturating spike counters and a gated weight-memory port. It sits between the AXI register/memory front end and the spike encoder, as the compute core of the network.

---
 rtl/if_core_pkg.sv | 37 +++
 rtl/if_neuron_unit.sv | 93 +++++++++
 rtl/if_recurrent_core.sv | 193 +++++++++++++++++++
 tb/tb_if_recurrent_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_core_pkg.sv
// Shared types and helpers for the recurrent integrate-and-fire core:
// potential type, sequencer states and a width-aware saturating adder.
package if_core_pkg;

    localparam int DEF_WEIGHT_SIZE = 16;
    localparam int DEF_POT_W       = 2 * DEF_WEIGHT_SIZE;

    typedef logic signed [DEF_POT_W-1:0] pot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Adds two sign-extended operands and clamps to the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [64:0] sum_s;
        logic signed [64:0] hi_s;
        logic signed [64:0] lo_s;
        sum_s = {a[63], a} + {b[63], b};
        hi_s  = (65'sd1 <<< (width - 32'd1)) - 65'sd1;
        lo_s  = -(65'sd1 <<< (width - 32'd1));
        if (sum_s > hi_s) begin
            return hi_s[63:0];
        end else if (sum_s < lo_s) begin
            return lo_s[63:0];
        end else begin
            return sum_s[63:0];
        end
    endfunction

endpackage

// File: rtl/if_neuron_unit.sv
// One integrate-and-fire neuron: membrane potential, refractory countdown,
// optional leak toward the rest value and a saturating spike counter.
module if_neuron_unit
    import if_core_pkg::*;
#(
    parameter int POT_W     = 32,
    parameter int THRESH    = 15,
    parameter int RESET     = 0,
    parameter int REFRAC    = 5,
    parameter int LEAK      = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    step_en,
    input  logic                    spike_clr,
    input  logic signed [POT_W-1:0] syn,
    output logic                    spike,
    output logic [CNT_WIDTH-1:0]    count
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [63:0]      THRESH_X = 64'(THRESH);
    localparam logic signed [63:0]      RESET_X  = 64'(RESET);
    localparam logic signed [63:0]      LEAK_X   = 64'(LEAK);
    localparam logic signed [POT_W-1:0] RESET_P  = POT_W'(RESET);

    logic signed [POT_W-1:0] v_q, v_d;
    logic [RW-1:0]           refrac_q, refrac_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    spike_q, spike_d;
    logic signed [63:0]      v_int_s;
    logic signed [63:0]      v_lk_s;

    // Next-state of one neuron for a single time step.
    always_comb begin
        v_d      = v_q;
        refrac_d = refrac_q;
        cnt_d    = cnt_q;
        spike_d  = spike_q;
        v_int_s  = sat_add(64'(v_q), 64'(syn), POT_W);
        // Leak only pulls a potential that sits above rest, and never past it.
        if ((LEAK > 0) && (v_int_s > RESET_X)) begin
            v_lk_s = ((v_int_s - LEAK_X) < RESET_X) ? RESET_X : (v_int_s - LEAK_X);
        end else begin
            v_lk_s = v_int_s;
        end

        if (clear) begin
            v_d      = RESET_P;
            refrac_d = {RW{1'b0}};
            cnt_d    = {CNT_WIDTH{1'b0}};
            spike_d  = 1'b0;
        end else if (step_en) begin
            if (refrac_q != {RW{1'b0}}) begin
                refrac_d = refrac_q - RW'(1);
                spike_d  = 1'b0;
            end else if (v_lk_s >= THRESH_X) begin
                spike_d  = 1'b1;
                v_d      = RESET_P;
                refrac_d = RW'(REFRAC);
                cnt_d    = (&cnt_q) ? cnt_q : (cnt_q + CNT_WIDTH'(1));
            end else begin
                spike_d  = 1'b0;
                v_d      = v_lk_s[POT_W-1:0];
            end
        end else if (spike_clr) begin
            spike_d = 1'b0;
        end else begin
            spike_d = spike_q;
        end
    end

    // Neuron state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= RESET_P;
            refrac_q <= {RW{1'b0}};
            cnt_q    <= {CNT_WIDTH{1'b0}};
            spike_q  <= 1'b0;
        end else begin
            v_q      <= v_d;
            refrac_q <= refrac_d;
            cnt_q    <= cnt_d;
            spike_q  <= spike_d;
        end
    end

    assign spike = spike_q;
    assign count = cnt_q;

endmodule

// File: rtl/if_recurrent_core.sv
// Recurrent IF layer with a start/busy/done step sequencer, gated weight
// memory port and per-neuron spike counter readout.
module if_recurrent_core
    import if_core_pkg::*;
#(
    parameter int WEIGHT_SIZE       = DEF_WEIGHT_SIZE,
    parameter int NUM_INPUTS        = 4,
    parameter int NUM_NEURONS       = 4,
    parameter int THRESH            = 15,
    parameter int RESET             = 0,
    parameter int REFRAC            = 5,
    parameter int LEAK              = 0,
    parameter int NUM_STEPS         = 16,
    parameter int CNT_WIDTH         = 8,
    parameter int NEURON_ADDR_WIDTH = 4,
    parameter int WEIGHT_ADDR_WIDTH = 4,
    localparam int CSEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    input  logic [NUM_INPUTS-1:0]                          spike_in,
    output logic [NUM_NEURONS-1:0]                         spike_out,
    input  logic [NEURON_ADDR_WIDTH+WEIGHT_ADDR_WIDTH-1:0] mem_addr,
    input  logic [WEIGHT_SIZE-1:0]                         mem_din,
    input  logic                                           mem_wen,
    output logic [WEIGHT_SIZE-1:0]                         mem_dout,
    input  logic [CSEL_W-1:0]                              cnt_sel,
    output logic [CNT_WIDTH-1:0]                           cnt_dout
);

    localparam int POT_W   = 2 * WEIGHT_SIZE;
    localparam int NUM_SYN = NUM_INPUTS + NUM_NEURONS;
    localparam int NAW     = NEURON_ADDR_WIDTH;
    localparam int SAW     = WEIGHT_ADDR_WIDTH;
    localparam int STEP_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic                busy_q, done_q;

    logic signed [WEIGHT_SIZE-1:0] w_q [NUM_NEURONS][NUM_SYN];
    logic signed [WEIGHT_SIZE-1:0] w_d [NUM_NEURONS][NUM_SYN];
    logic [WEIGHT_SIZE-1:0]        mem_dout_q, mem_dout_d;
    logic [CNT_WIDTH-1:0]          cnt_dout_q, cnt_dout_d;

    logic signed [POT_W-1:0] syn_s [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]    cnt_s [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  spk_s;
    logic [NAW-1:0]          addr_n_s;
    logic [SAW-1:0]          addr_s_s;
    logic                    clear_s, step_en_s, spike_clr_s, wr_ok_s;

    assign addr_n_s    = mem_addr[NAW+SAW-1:SAW];
    assign addr_s_s    = mem_addr[SAW-1:0];
    assign clear_s     = (state_q == IDLE) && start;
    assign step_en_s   = (state_q == RUN);
    assign spike_clr_s = (state_q == DONE);
    assign wr_ok_s     = (state_q == IDLE) && mem_wen;

    // Step sequencer with registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= {STEP_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        step_q  <= {STEP_W{1'b0}};
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Weight write (IDLE only, in-range only) and old-value read mux.
    always_comb begin
        mem_dout_d = {WEIGHT_SIZE{1'b0}};
        for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int s = 0; s < NUM_SYN; s++) begin
                if (addr_n_s == NAW'(n) && addr_s_s == SAW'(s)) begin
                    mem_dout_d = w_q[n][s];
                    w_d[n][s]  = wr_ok_s ? mem_din : w_q[n][s];
                end else begin
                    w_d[n][s]  = w_q[n][s];
                end
            end
        end
    end

    // Synaptic sum: external spikes now, recurrent spikes from the previous step.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            syn_s[n] = {POT_W{1'b0}};
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (spike_in[i]) begin
                    syn_s[n] = syn_s[n] + POT_W'(w_q[n][i]);
                end else begin
                    syn_s[n] = syn_s[n];
                end
            end
            for (int j = 0; j < NUM_NEURONS; j++) begin
                if (spk_s[j]) begin
                    syn_s[n] = syn_s[n] + POT_W'(w_q[n][NUM_INPUTS+j]);
                end else begin
                    syn_s[n] = syn_s[n];
                end
            end
        end
    end

    // Spike counter readout select.
    always_comb begin
        cnt_dout_d = {CNT_WIDTH{1'b0}};
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (cnt_sel == CSEL_W'(n)) begin
                cnt_dout_d = cnt_s[n];
            end else begin
                cnt_dout_d = cnt_dout_d;
            end
        end
    end

    // Weight array and registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int s = 0; s < NUM_SYN; s++) begin
                    w_q[n][s] <= {WEIGHT_SIZE{1'b0}};
                end
            end
            mem_dout_q <= {WEIGHT_SIZE{1'b0}};
            cnt_dout_q <= {CNT_WIDTH{1'b0}};
        end else begin
            w_q        <= w_d;
            mem_dout_q <= mem_dout_d;
            cnt_dout_q <= cnt_dout_d;
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
        if_neuron_unit #(
            .POT_W    (POT_W),
            .THRESH   (THRESH),
            .RESET    (RESET),
            .REFRAC   (REFRAC),
            .LEAK     (LEAK),
            .CNT_WIDTH(CNT_WIDTH)
        ) u_neuron (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_s),
            .step_en  (step_en_s),
            .spike_clr(spike_clr_s),
            .syn      (syn_s[g]),
            .spike    (spk_s[g]),
            .count    (cnt_s[g])
        );
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign spike_out = spk_s;
    assign mem_dout  = mem_dout_q;
    assign cnt_dout  = cnt_dout_q;

endmodule

// File: tb/tb_if_recurrent_core.sv
// Bench for if_recurrent_core: two parameterisations driven in lockstep and
// compared step by step against a plain-arithmetic layer model.
module tb_if_recurrent_core;

    localparam int NI   = 4;
    localparam int NN   = 4;
    localparam int NS   = 16;
    localparam int NSYN = NI + NN;
    localparam longint PMAX = 64'sd2147483647;
    localparam longint PMIN = -PMAX - 64'sd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  spike_in;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_wen;
    logic [1:0]  cnt_sel;

    logic        busy_a, done_a, busy_b, done_b;
    logic [3:0]  spk_a, spk_b;
    logic [15:0] dout_a, dout_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    if_recurrent_core dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .spike_in(spike_in), .spike_out(spk_a), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_a),
        .cnt_sel(cnt_sel), .cnt_dout(cnt_a)
    );

    if_recurrent_core #(.LEAK(2), .REFRAC(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .spike_in(spike_in), .spike_out(spk_b), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_b),
        .cnt_sel(cnt_sel), .cnt_dout(cnt_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    longint     wm [NN][NSYN];
    logic [3:0] sin [NS];
    logic [3:0] exp_spk [2][NS];
    int         exp_cnt [2][NN];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Whole-sample reference: potentials as plain integers, one pass per step.
    task automatic model_run(input int c, input longint leak, input int refrac, input longint cmax);
        longint     v [NN];
        int         rf [NN];
        longint     cnt [NN];
        logic [3:0] prev, cur;
        longint     syn, v1;
        prev = 4'b0;
        for (int n = 0; n < NN; n++) begin
            v[n] = 0; rf[n] = 0; cnt[n] = 0;
        end
        for (int k = 0; k < NS; k++) begin
            cur = 4'b0;
            for (int n = 0; n < NN; n++) begin
                syn = 0;
                for (int i = 0; i < NI; i++) if (sin[k][i]) syn += wm[n][i];
                for (int j = 0; j < NN; j++) if (prev[j]) syn += wm[n][NI+j];
                if (rf[n] > 0) begin
                    rf[n]--;
                end else begin
                    v1 = v[n] + syn;
                    if (v1 > PMAX) v1 = PMAX;
                    if (v1 < PMIN) v1 = PMIN;
                    if (leak > 0 && v1 > 0) v1 = (v1 - leak < 0) ? 0 : v1 - leak;
                    if (v1 >= 15) begin
                        cur[n] = 1'b1; v[n] = 0; rf[n] = refrac;
                        if (cnt[n] < cmax) cnt[n]++;
                    end else begin
                        v[n] = v1;
                    end
                end
            end
            exp_spk[c][k] = cur;
            prev = cur;
        end
        for (int n = 0; n < NN; n++) exp_cnt[c][n] = int'(cnt[n]);
    endtask

    task automatic model_both();
        model_run(0, 0, 5, 255);
        model_run(1, 2, 0, 3);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; spike_in = 4'b0; mem_addr = 8'h0;
        mem_din = 16'h0; mem_wen = 1'b0; cnt_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < NN; n++) for (int s = 0; s < NSYN; s++) wm[n][s] = 0;
    endtask

    task automatic mem_write(input int n, input int s, input logic [15:0] val);
        logic [15:0] old;
        old = (n < NN && s < NSYN) ? 16'(wm[n][s]) : 16'h0;
        mem_addr = {4'(n), 4'(s)}; mem_din = val; mem_wen = 1'b1;
        @(posedge clk); #1;
        mem_wen = 1'b0;
        check_eq("rd_during_wr_a", 64'(dout_a), 64'(old));
        check_eq("rd_during_wr_b", 64'(dout_b), 64'(old));
        if (n < NN && s < NSYN) wm[n][s] = longint'($signed(val));
    endtask

    task automatic mem_read(input int n, input int s);
        logic [15:0] e16;
        e16 = (n < NN && s < NSYN) ? 16'(wm[n][s]) : 16'h0;
        mem_addr = {4'(n), 4'(s)}; mem_wen = 1'b0;
        @(posedge clk); #1;
        check_eq("mem_dout_a", 64'(dout_a), 64'(e16));
        check_eq("mem_dout_b", 64'(dout_b), 64'(e16));
    endtask

    task automatic run_sample(input bit wr_in_run, input int abort_at);
        int seen;
        start = 1'b1; spike_in = 4'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_at_step0", 64'(busy_a), 64'(1));
        check_eq("spk_at_step0", 64'(spk_a), 64'(0));
        spike_in = sin[0];
        for (int k = 0; k < NS; k++) begin
            if (wr_in_run && k == 3) begin
                mem_addr = 8'h00; mem_din = 16'd1234; mem_wen = 1'b1;
            end else begin
                mem_wen = 1'b0;
            end
            start = (k == 7);
            @(posedge clk); #1;
            check_eq("spike_out_a", 64'(spk_a), 64'(exp_spk[0][k]));
            check_eq("spike_out_b", 64'(spk_b), 64'(exp_spk[1][k]));
            if (abort_at == k) begin
                rst = 1'b1; #1;
                check_eq("abort_busy", 64'(busy_a), 64'(0));
                check_eq("abort_spk_a", 64'(spk_a), 64'(0));
                check_eq("abort_spk_b", 64'(spk_b), 64'(0));
                #1 rst = 1'b0;
                start = 1'b0; mem_wen = 1'b0; spike_in = 4'b0;
                for (int n = 0; n < NN; n++) for (int s = 0; s < NSYN; s++) wm[n][s] = 0;
                seen = 0;
                repeat (NS + 2) begin
                    @(posedge clk); #1;
                    if (done_a || done_b || busy_a) seen++;
                end
                check_eq("no_done_after_abort", 64'(seen), 64'(0));
                return;
            end
            if (k < NS - 1) begin
                check_eq("busy_in_run", 64'(busy_a), 64'(1));
                check_eq("done_in_run", 64'(done_a), 64'(0));
                spike_in = sin[k+1];
            end else begin
                check_eq("done_pulse_a", 64'(done_a), 64'(1));
                check_eq("done_pulse_b", 64'(done_b), 64'(1));
                check_eq("busy_in_done", 64'(busy_a), 64'(0));
                spike_in = 4'b0;
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("done_one_cycle", 64'(done_a), 64'(0));
        check_eq("idle_busy", 64'(busy_a), 64'(0));
        check_eq("idle_spk_a", 64'(spk_a), 64'(0));
        check_eq("idle_spk_b", 64'(spk_b), 64'(0));
        @(posedge clk); #1;
        check_eq("start_in_done_ignored", 64'(busy_a), 64'(0));
        for (int n = 0; n < NN; n++) begin
            cnt_sel = 2'(n);
            @(posedge clk); #1;
            check_eq("cnt_dout_a", 64'(cnt_a), 64'(exp_cnt[0][n]));
            check_eq("cnt_dout_b", 64'(cnt_b), 64'(exp_cnt[1][n]));
        end
    endtask

    task automatic fill_sin(input logic [3:0] pat);
        for (int k = 0; k < NS; k++) sin[k] = pat;
    endtask

    initial begin
        do_reset();
        check_eq("rst_busy", 64'(busy_a), 64'(0));
        check_eq("rst_done", 64'(done_a), 64'(0));
        check_eq("rst_spk", 64'(spk_a), 64'(0));
        check_eq("rst_dout", 64'(dout_a), 64'(0));
        check_eq("rst_cnt", 64'(cnt_a), 64'(0));

        // Readback and dropped out-of-range writes.
        mem_write(0, 0, 16'd7);
        mem_read(0, 0);
        mem_write(4, 0, 16'd99);
        mem_write(0, 8, 16'd55);
        mem_read(4, 0);
        mem_read(0, 8);
        mem_read(0, 0);

        // Single drive plus recurrent chain; a write in RUN must be dropped.
        mem_write(0, 0, 16'd5);
        mem_write(1, NI + 0, 16'd20);
        fill_sin(4'b0001);
        model_both();
        run_sample(1'b1, -1);
        mem_read(0, 0);
        mem_read(1, NI);

        // Leak: net +1 per step in the leaky instance.
        mem_write(1, NI + 0, 16'd0);
        mem_write(0, 0, 16'd3);
        model_both();
        run_sample(1'b0, -1);

        // Strong negative drive must not wrap; neuron 1 saturates the 2-bit counter.
        mem_write(0, 0, 16'h8000);
        mem_write(1, 1, 16'd15);
        fill_sin(4'b0011);
        model_both();
        run_sample(1'b0, -1);

        // Reset mid-run, then an identical restart.
        mem_write(0, 0, 16'd5);
        mem_write(1, NI + 0, 16'd20);
        fill_sin(4'b0001);
        model_both();
        run_sample(1'b0, 5);
        mem_write(0, 0, 16'd5);
        mem_write(1, NI + 0, 16'd20);
        model_both();
        run_sample(1'b0, -1);

        // Random weights and spike trains.
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < NN; n++)
                for (int s = 0; s < NSYN; s++)
                    mem_write(n, s, 16'($signed($urandom_range(0, 30)) - 10));
            for (int k = 0; k < NS; k++) sin[k] = 4'($urandom_range(0, 15));
            model_both();
            run_sample(1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
